// File: rtl/four_to_two_encoder_pkg.sv
// ----------------------------------------------------------------------------
// four_to_two_encoder_pkg : shared code constants and helpers for the encoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package four_to_two_encoder_pkg;

  localparam int DIN_W = 4;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] IDX0 = 2'b00;
  localparam logic [IDX_W-1:0] IDX1 = 2'b01;
  localparam logic [IDX_W-1:0] IDX2 = 2'b10;
  localparam logic [IDX_W-1:0] IDX3 = 2'b11;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             any_set;
    logic             multi_set;
  } enc_result_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic has_multiple(input logic [DIN_W-1:0] v);
    logic [DIN_W-1:0] lowered;
    lowered = v & (v - DIN_W'(1));
    return |lowered;
  endfunction

endpackage : four_to_two_encoder_pkg

`default_nettype wire

// File: rtl/four_to_two_encoder_prio.sv
// ----------------------------------------------------------------------------
// enc4to2_prio : combinational highest-bit-wins 4:2 encoder with flags
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module enc4to2_prio
  import four_to_two_encoder_pkg::*;
(
  input  logic [DIN_W-1:0] din,
  output logic [IDX_W-1:0] idx,
  output logic             any_set,
  output logic             multi_set
);

  enc_result_t res;

  always_comb begin
    res.idx       = IDX0;
    res.any_set   = |din;
    res.multi_set = has_multiple(din);
    if (din[3])      res.idx = IDX3;
    else if (din[2]) res.idx = IDX2;
    else if (din[1]) res.idx = IDX1;
    else             res.idx = IDX0;
  end

  assign idx       = res.idx;
  assign any_set   = res.any_set;
  assign multi_set = res.multi_set;

endmodule : enc4to2_prio

`default_nettype wire

// File: rtl/four_to_two_encoder.sv
// ----------------------------------------------------------------------------
// four_to_two_encoder : registered 4:2 priority encoder with saturating error count
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module four_to_two_encoder
  import four_to_two_encoder_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [IDX_W-1:0] dout,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] idx;
  logic             any_set;
  logic             multi_set;
  logic             err_event;

  enc4to2_prio u_prio (
    .din       (din),
    .idx       (idx),
    .any_set   (any_set),
    .multi_set (multi_set)
  );

  // An empty or multi-hot request both count as a malformed sample.
  assign err_event = !any_set || multi_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= IDX0;
      valid   <= 1'b0;
      multi   <= 1'b0;
      err_cnt <= '0;
    end else if (en) begin
      dout  <= idx;
      valid <= any_set;
      multi <= multi_set;
      if (err_event && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule : four_to_two_encoder

`default_nettype wire

// File: tb/tb_four_to_two_encoder.sv
// ----------------------------------------------------------------------------
// tb_four_to_two_encoder : directed self-checking bench for four_to_two_encoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_four_to_two_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] din;
  logic [1:0] dout;
  logic       valid;
  logic       multi;
  logic [7:0] err_cnt;

  logic       en2;
  logic [3:0] din2;
  logic [1:0] dout2;
  logic       valid2;
  logic       multi2;
  logic [1:0] err_cnt2;

  int passed = 0;
  int total  = 0;

  four_to_two_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout), .valid(valid), .multi(multi), .err_cnt(err_cnt)
  );

  four_to_two_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .din(din2),
    .dout(dout2), .valid(valid2), .multi(multi2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic [3:0] d, input logic e);
    din = d;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] d, input logic v,
                            input logic m, input logic [7:0] c);
    check({tag, ".dout"},    16'(dout),    16'(d));
    check({tag, ".valid"},   16'(valid),   16'(v));
    check({tag, ".multi"},   16'(multi),   16'(m));
    check({tag, ".err_cnt"}, 16'(err_cnt), 16'(c));
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst_n = 1'b1;
    en    = 1'b1;
    din   = 4'b1000;
    en2   = 1'b0;
    din2  = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 8'd0);
    check("reset.err_cnt2", 16'(err_cnt2), 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(4'b0001, 1'b1); expect_out("hot0", 2'b00, 1'b1, 1'b0, 8'd0);
    step(4'b0010, 1'b1); expect_out("hot1", 2'b01, 1'b1, 1'b0, 8'd0);
    step(4'b0100, 1'b1); expect_out("hot2", 2'b10, 1'b1, 1'b0, 8'd0);
    step(4'b1000, 1'b1); expect_out("hot3", 2'b11, 1'b1, 1'b0, 8'd0);

    step(4'b0000, 1'b1); expect_out("zero", 2'b00, 1'b0, 1'b0, 8'd1);

    step(4'b1010, 1'b1); expect_out("multi_1010", 2'b11, 1'b1, 1'b1, 8'd2);
    step(4'b0110, 1'b1); expect_out("multi_0110", 2'b10, 1'b1, 1'b1, 8'd3);
    step(4'b0011, 1'b1); expect_out("multi_0011", 2'b01, 1'b1, 1'b1, 8'd4);

    step(4'b0100, 1'b1); expect_out("hold_load", 2'b10, 1'b1, 1'b0, 8'd4);
    step(4'b0001, 1'b0); expect_out("hold_1", 2'b10, 1'b1, 1'b0, 8'd4);
    step(4'b0001, 1'b0); expect_out("hold_2", 2'b10, 1'b1, 1'b0, 8'd4);
    step(4'b0001, 1'b0); expect_out("hold_3", 2'b10, 1'b1, 1'b0, 8'd4);
    step(4'b0000, 1'b0); expect_out("hold_zero", 2'b10, 1'b1, 1'b0, 8'd4);
    step(4'b1111, 1'b0); expect_out("hold_multi", 2'b10, 1'b1, 1'b0, 8'd4);

    // reset mid-operation discards the pending sample
    din = 4'b1000;
    en  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expect_out("midreset", 2'b00, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0010, 1'b1); expect_out("post_reset", 2'b01, 1'b1, 1'b0, 8'd0);

    // saturation on the narrow counter
    en   = 1'b0;
    en2  = 1'b1;
    din2 = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat_%0d", i), 16'(err_cnt2), 16'(sat_exp[i]));
    end
    check("sat.valid2", 16'(valid2), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_four_to_two_encoder

`default_nettype wire

// File: doc/four_to_two_encoder.md
FOUR_TO_TWO_ENCODER -- requirements
Module: four_to_two_encoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the saturating error counter; legal range 2..16.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 Port en  input  1: sample enable; din is captured only in cycles where en=1.
REQ-005 Port din  input  4: request vector, nominally one-hot.
REQ-006 Port dout  output  2: registered binary index of the selected din bit.
REQ-007 Port valid  output  1: registered; 1 when the captured din had at least one bit set.
REQ-008 Port multi  output  1: registered; 1 when the captured din had more than one bit set.
REQ-009 Port err_cnt  output  CNT_W: count of captured samples with multi=1 or din=0000.

Function
REQ-010 Encoding SHALL be 0001->00, 0010->01, 0100->10, 1000->11.
REQ-011 Multi-hot din SHALL use priority encoding: highest set bit wins (e.g. 1010->11, 0110->10), with multi=1.
REQ-012 din=0000 SHALL give dout=00, valid=0, multi=0.
REQ-013 Latency SHALL be exactly one clock: din sampled at edge N appears on dout/valid/multi after edge N.
REQ-014 When en=0, dout, valid and multi SHALL hold their previous values and err_cnt SHALL not change.
REQ-015 err_cnt SHALL increment by 1 on each enabled edge where din=0000 or popcount(din)>1.
REQ-016 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 Outputs SHALL be glitch-free registered values; no combinational path from din to any output.
REQ-018 X/Z on din is not supported; behaviour is unspecified.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately force dout=00, valid=0, multi=0 and err_cnt=0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard any sample in flight; after deassertion the first enabled edge captures fresh din.
REQ-021 Deassertion SHALL be treated as synchronous to clk by the integrator; the block adds no internal synchronizer.

Structure
REQ-022 Shared package four_to_two_encoder_pkg SHALL hold the code constants IDX0..IDX3 (2'b00..2'b11) and the din width constant DIN_W=4.
REQ-023 A combinational sub-module enc4to2_prio SHALL compute index, any-set and multi-set from din; the top level holds only registers and the counter.

Verification
REQ-024 Reset: rst_n=0 with din=1000, en=1 -> dout=00, valid=0, multi=0, err_cnt=0 with no clock edge required.
REQ-025 One-hot sweep: din=0001,0010,0100,1000 on consecutive enabled edges -> dout=00,01,10,11 one cycle later, valid=1, multi=0, err_cnt unchanged.
REQ-026 Zero input: din=0000, en=1 for one edge -> dout=00, valid=0, multi=0, err_cnt increments by 1.
REQ-027 Multi-hot: din=1010, then 0110 -> dout=11 then 10, multi=1 both cycles, err_cnt +2.
REQ-028 Enable hold: din=0100 with en=1, then din=0001 with en=0 for 3 edges -> dout stays 10, valid=1, err_cnt unchanged.
REQ-029 Saturation, CNT_W=2: 5 enabled edges with din=0000 -> err_cnt reads 1,2,3,3,3.
